// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder over 2**ADDR_W x DATA_W storage.
// Optional write protection of the top address block is enabled by DMEM_WPROT_EN.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic              Wr,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WData,
`ifdef DMEM_WPROT_EN
  input  logic              WProt,
  output logic              Err,
`endif
  output logic [DATA_W-1:0] RData,
  output logic              Ready,
  output logic              Busy
);

  localparam int CNT_W = 4;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_wr;
  logic              accept;
  logic              drop;
  logic              mem_we;

  logic [DATA_W-1:0] mem [DEPTH];

  assign accept = (state_q == S_IDLE) && Req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_addr = addr_q;
    rd_wr   = wr_q;
    unique case (state_q)
      S_IDLE: begin
        if (Req) begin
          wr_d    = Wr;
          addr_d  = Addr;
          wdata_d = WData;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          rd_addr = Addr;
          rd_wr   = Wr;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Read data is fetched on the edge entering RESP so it is valid with Ready.
    if ((state_d == S_RESP) && (state_q != S_RESP) && !rd_wr)
      rdata_d = mem[rd_addr];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef DMEM_WPROT_EN
  logic prot_q, prot_d;

  assign prot_d = accept ? (Wr & WProt & (&Addr[ADDR_W-1 -: 4])) : prot_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) prot_q <= 1'b0;
    else        prot_q <= prot_d;
  end

  assign drop = prot_q;
  assign Err  = (state_q == S_RESP) & prot_q;
`else
  assign drop = 1'b0;
`endif

  // Writes commit on the edge leaving RESP; an async reset forces IDLE first.
  assign mem_we = (state_q == S_RESP) & wr_q & ~drop;

  always_ff @(posedge Clk) begin
    if (mem_we) mem[addr_q] <= wdata_q;
  end

  assign RData = rdata_q;
  assign Ready = (state_q == S_RESP);
  assign Busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector table plus multi-cycle sequences.
// DUT a uses two wait states, DUT b uses zero wait states.
module tb_dmem_responder;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;

  logic        reqA = 1'b0, wrA = 1'b0;
  logic [7:0]  addrA = '0;
  logic [15:0] wdA = '0, rdA;
  logic        rdyA, bsyA;

  logic        reqB = 1'b0, wrB = 1'b0;
  logic [7:0]  addrB = '0;
  logic [15:0] wdB = '0, rdB;
  logic        rdyB, bsyB;

`ifdef DMEM_WPROT_EN
  logic        wpA = 1'b0, errA;
  logic        wpB = 1'b0, errB;
`endif

  logic        err_seen;

  always #5 Clk = ~Clk;

  dmem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2)) u_a (
    .Clk   (Clk),
    .Reset (Reset),
    .Req   (reqA),
    .Wr    (wrA),
    .Addr  (addrA),
    .WData (wdA),
`ifdef DMEM_WPROT_EN
    .WProt (wpA),
    .Err   (errA),
`endif
    .RData (rdA),
    .Ready (rdyA),
    .Busy  (bsyA)
  );

  dmem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0)) u_b (
    .Clk   (Clk),
    .Reset (Reset),
    .Req   (reqB),
    .Wr    (wrB),
    .Addr  (addrB),
    .WData (wdB),
`ifdef DMEM_WPROT_EN
    .WProt (wpB),
    .Err   (errB),
`endif
    .RData (rdB),
    .Ready (rdyB),
    .Busy  (bsyB)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tv [12];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One access on DUT a; Ready must appear two edges after the accepting edge.
  task automatic access(input logic w, input logic [7:0] a,
                        input logic [15:0] d, input logic [15:0] exp,
                        input string nm);
    int lat;
    reqA = 1'b1; wrA = w; addrA = a; wdA = d;
    step();
    reqA = 1'b0; wrA = 1'b0; addrA = '0; wdA = '0;
    chk({nm, " busy_acc"}, bsyA, 1);
    lat = 0;
    while (!rdyA && lat < 20) begin
      step();
      lat++;
    end
    chk({nm, " latency"}, lat, 2);
    chk({nm, " rdata"}, rdA, exp);
    err_seen = 1'b0;
`ifdef DMEM_WPROT_EN
    err_seen = errA;
`endif
    step();
    chk({nm, " ready_drop"}, {rdyA, bsyA}, 0);
`ifdef DMEM_WPROT_EN
    chk({nm, " err_drop"}, errA, 0);
`endif
  endtask

  initial begin
    int cnt;
    logic [3:0] bpat;
    tv[0]  = '{1'b1, 8'h12, 16'hBEEF, 16'h0000};
    tv[1]  = '{1'b0, 8'h12, 16'h0000, 16'hBEEF};
    tv[2]  = '{1'b1, 8'h00, 16'h1111, 16'hBEEF};
    tv[3]  = '{1'b1, 8'hFF, 16'h2222, 16'hBEEF};
    tv[4]  = '{1'b0, 8'h00, 16'h0000, 16'h1111};
    tv[5]  = '{1'b0, 8'hFF, 16'h0000, 16'h2222};
    tv[6]  = '{1'b1, 8'h12, 16'h0F0F, 16'h2222};
    tv[7]  = '{1'b0, 8'h12, 16'h0000, 16'h0F0F};
    tv[8]  = '{1'b1, 8'h05, 16'h0505, 16'h0F0F};
    tv[9]  = '{1'b1, 8'h06, 16'h0606, 16'h0F0F};
    tv[10] = '{1'b1, 8'h20, 16'hAAAA, 16'h0F0F};
    tv[11] = '{1'b1, 8'hF3, 16'h0001, 16'h0F0F};

    // Reset for three cycles, then idle without requests.
    repeat (3) step();
    chk("rst_a", {rdA, rdyA, bsyA}, 0);
    chk("rst_b", {rdB, rdyB, bsyB}, 0);
    Reset = 1'b1;
    cnt = 0;
    repeat (5) begin
      step();
      if (rdyA || rdyB || bsyA || bsyB) cnt++;
    end
    chk("idle_quiet", cnt, 0);

    for (int i = 0; i < 12; i++)
      access(tv[i].wr, tv[i].addr, tv[i].wdata, tv[i].exp_rd,
             $sformatf("vec%0d", i));

    // Request changes while busy are ignored.
    reqA = 1'b1; wrA = 1'b0; addrA = 8'h05;
    step();
    reqA = 1'b1; addrA = 8'h06;
    step();
    chk("ign busy_wait", bsyA, 1);
    reqA = 1'b0; addrA = '0;
    cnt = 0;
    repeat (6) begin
      if (rdyA) begin
        cnt++;
        chk("ign rdata", rdA, 16'h0505);
      end
      step();
    end
    chk("ign one_ready", cnt, 1);
    chk("ign idle", bsyA, 0);
    access(1'b0, 8'h06, 16'h0, 16'h0606, "rd06");

    // Reset during WAIT aborts the pending write.
    reqA = 1'b1; wrA = 1'b1; addrA = 8'h20; wdA = 16'h1234;
    step();
    reqA = 1'b0; wrA = 1'b0; addrA = '0; wdA = '0;
    Reset = 1'b0;
    #1;
    chk("abort outs", {rdA, rdyA, bsyA}, 0);
    cnt = 0;
    repeat (3) begin
      step();
      if (rdyA) cnt++;
    end
    chk("abort no_ready", cnt, 0);
    Reset = 1'b1;
    cnt = 0;
    repeat (4) begin
      step();
      if (rdyA) cnt++;
    end
    chk("abort still_quiet", cnt, 0);
    access(1'b0, 8'h20, 16'h0, 16'hAAAA, "rd20");
    access(1'b0, 8'hF3, 16'h0, 16'h0001, "rdF3");

`ifdef DMEM_WPROT_EN
    wpA = 1'b1;
    access(1'b1, 8'hF3, 16'h5555, 16'h0001, "prot_wr");
    chk("prot err", err_seen, 1);
    access(1'b1, 8'hE3, 16'h7777, 16'h0001, "unprot_wr");
    chk("unprot err", err_seen, 0);
    access(1'b0, 8'hF3, 16'h0, 16'h0001, "prot_rd");
    chk("prot_rd err", err_seen, 0);
    access(1'b0, 8'hE3, 16'h0, 16'h7777, "unprot_rd");
    wpA = 1'b0;
    access(1'b1, 8'hF3, 16'h5555, 16'h7777, "open_wr");
    chk("open err", err_seen, 0);
    access(1'b0, 8'hF3, 16'h0, 16'h5555, "open_rd");
`endif

    // Zero wait states with Req held high: writes then reads back to back.
    reqB = 1'b1; wrB = 1'b1; addrB = 8'h00; wdB = 16'h0A0A;
    step();
    chk("b w0 ready", {rdyB, bsyB}, 2'b11);
    addrB = 8'hFF; wdB = 16'hF0F0;
    step();
    chk("b w0 done", {rdyB, bsyB}, 2'b00);
    step();
    chk("b w1 ready", {rdyB, bsyB}, 2'b11);
    chk("b w1 rdata", rdB, 16'h0000);
    wrB = 1'b0; addrB = 8'h00;
    step();
    bpat[3] = bsyB;
    chk("b w1 done", rdyB, 0);
    step();
    bpat[2] = bsyB;
    chk("b r0 ready", rdyB, 1);
    chk("b r0 rdata", rdB, 16'h0A0A);
    addrB = 8'hFF;
    step();
    bpat[1] = bsyB;
    chk("b r0 hold", rdB, 16'h0A0A);
    step();
    bpat[0] = bsyB;
    chk("b r1 ready", rdyB, 1);
    chk("b r1 rdata", rdB, 16'hF0F0);
    reqB = 1'b0;
    chk("b busy_pat", bpat, 4'b0101);
    step();
    chk("b r1 done", {rdyB, bsyB}, 2'b00);
    step();
    chk("b quiet", {rdyB, bsyB, rdB}, {2'b00, 16'hF0F0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the processor's data-memory interface. It accepts single-word read/write requests from the controller/datapath through a req/ready handshake. Each access completes after a programmable number of wait states against an internal 256x16 storage array. The block sits between the processor top and the data memory and gives it realistic, multi-cycle memory timing.

Parameters:
ADDR_W, 8, address width; storage depth = 2**ADDR_W words
DATA_W, 16, data word width
WAIT_CYCLES, 2, wait states inserted between request acceptance and response (0..15)

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-low reset
Req  input  1  access request; sampled only in IDLE
Wr  input  1  1 = write, 0 = read; captured with Req
Addr  input  ADDR_W  word address; captured with Req
WData  input  DATA_W  write data; captured with Req
RData  output  DATA_W  read data; valid in the Ready cycle of a read, held until the next read completes
Ready  output  1  single-cycle completion pulse
Busy  output  1  high from the cycle after acceptance through the Ready cycle inclusive

Behaviour:
- Reset (Reset=0, async): state=IDLE, wait counter=0, RData=0, Ready=0, Busy=0, captured Wr/Addr/WData=0. Storage array is not cleared; contents are undefined after power-up and retained across reset.
- Reset asserted mid-access aborts the access. A pending write is not committed. No Ready pulse is issued.
- States:
  - IDLE: on a rising edge with Req=1, capture Wr/Addr/WData, load counter=WAIT_CYCLES, set Busy=1. If WAIT_CYCLES=0, go to RESP; otherwise go to WAIT.
  - WAIT: decrement counter each cycle. When counter reaches 1 on an edge, go to RESP. Req is ignored.
  - RESP: for one cycle, Ready=1 and Busy stays 1. A write commits mem[Addr]<=WData on the edge leaving RESP. A read drives RData=mem[Addr] registered so it is valid during the RESP cycle. On the next edge go to IDLE with Busy=0 and Ready=0.
- Latency: Ready asserts WAIT_CYCLES+1 cycles after the accepting edge. Minimum spacing between accepted requests is WAIT_CYCLES+2 cycles. A Req held high in IDLE is accepted immediately.
- Request changes while Busy=1 have no effect. Captured values are used for the whole access.
- Read-after-write to the same address returns the new value, since the write commits before the next access can be accepted.
- Address has no wrap or overflow concern: the ADDR_W bits index the full array.
- RData is unchanged by writes and by reset-free idle cycles.

Optional Feature:
Macro DMEM_WPROT_EN.
- Defined: adds input WProt (1 bit) and output Err (1 bit, reset 0).
  - A write whose captured Addr has its upper 4 bits all 1 (0xF0..0xFF for ADDR_W=8), accepted while WProt=1, is dropped: the storage is unchanged.
  - Such a dropped write still completes normally with Ready=1. Err=1 in that same cycle only.
  - WProt is sampled at acceptance. Reads are never blocked.
- Not defined: no WProt/Err ports, and all writes commit.

Test Plan:
- Reset then idle: Reset=0 for 3 cycles, then release -> RData=0, Ready=0, Busy=0; Ready never asserts without Req.
- Write then read, WAIT_CYCLES=2: write Addr=0x12 WData=0xBEEF, then read Addr=0x12 -> each Ready pulses exactly 3 cycles after acceptance; read returns RData=0xBEEF.
- Zero wait states, WAIT_CYCLES=0: back-to-back reads of 0x00 and 0xFF with Req held high -> Ready every 2nd cycle; Busy toggles 1,0,1,0.
- Ignore while busy: accept a read of 0x05, then change Addr to 0x06 and pulse Req during WAIT -> only one Ready; RData=mem[0x05]; no second access starts.
- Reset mid-write: accept write 0x20<-0x1234 (prior value 0xAAAA), assert Reset during WAIT, release, then read 0x20 -> RData=0xAAAA; no Ready is issued for the aborted write.
- With DMEM_WPROT_EN: WProt=1, write 0xF3<-0x5555 (prior value 0x0001) -> Ready=1 and Err=1 in the same cycle; a subsequent read of 0xF3 returns 0x0001. With WProt=0, the same write commits and Err stays 0.
